// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Fault encodings double as the rsp_fault wire values.
package lsu_pkg;

    localparam int unsigned FUNCT3_BITS = 3;

    // funct3[1:0] access size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        F_OK       = 2'd0,
        F_MISALIGN = 2'd1,
        F_ILLEGAL  = 2'd2,
        F_RANGE    = 2'd3
    } fault_t;

endpackage

// File: rtl/lsu_check.sv
// Combinational fault classifier for a load/store request.
// Priority: illegal funct3, then out-of-range address, then misalignment.
module lsu_check
    import lsu_pkg::*;
#(
    parameter int unsigned BUS_BITS  = 64,
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic                   we,
    input  logic [FUNCT3_BITS-1:0] funct3,
    input  logic [BUS_BITS-1:0]    addr,
    output fault_t                 fault
);

    logic                illegal;
    logic                range_err;
    logic                misalign;
    logic [BUS_BITS-1:0] align_mask;

    always_comb begin
        illegal   = we ? funct3[2] : (funct3 == 3'b111);
        range_err = (addr >> ADDR_BITS) != '0;

        align_mask = '0;
        case (funct3[1:0])
            SZ_B:    align_mask[2:0] = 3'b000;
            SZ_H:    align_mask[2:0] = 3'b001;
            SZ_W:    align_mask[2:0] = 3'b011;
            default: align_mask[2:0] = 3'b111;
        endcase
        misalign = (addr & align_mask) != '0;

        if (illegal) begin
            fault = F_ILLEGAL;
        end else if (range_err) begin
            fault = F_RANGE;
        end else if (misalign) begin
            fault = F_MISALIGN;
        end else begin
            fault = F_OK;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request in flight, faults answered without touching memory.
// Memory returns registered, already-extended load data one cycle after issue.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned BUS_BITS  = 64,
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [FUNCT3_BITS-1:0] req_funct3,
    input  logic [BUS_BITS-1:0]    req_addr,
    input  logic [BUS_BITS-1:0]    req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [BUS_BITS-1:0]    rsp_data,
    output logic [1:0]             rsp_fault,
    output logic                   mem_we,
    output logic [BUS_BITS-1:0]    mem_addr,
    output logic [FUNCT3_BITS-1:0] mem_funct3,
    output logic [BUS_BITS-1:0]    mem_wdata,
    input  logic [BUS_BITS-1:0]    mem_rdata
);

    state_t state;
    state_t state_next;
    fault_t req_fault;
    fault_t fault_q;
    logic   we_q;
    logic   accept;
    logic   clean;

    lsu_check #(
        .BUS_BITS (BUS_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) u_check (
        .we    (req_we),
        .funct3(req_funct3),
        .addr  (req_addr),
        .fault (req_fault)
    );

    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign clean     = (req_fault == F_OK);
    assign rsp_valid = (state == RESP);
    // Decoded from state so an async reset drops the write strobe immediately
    assign mem_we    = (state == ISSUE) && we_q;
    assign rsp_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_next = clean ? ISSUE : RESP;
                end else if ((state == RESP) && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            ISSUE:   state_next = we_q ? RESP : CAPTURE;
            CAPTURE: state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_funct3 <= '0;
            mem_wdata  <= '0;
            rsp_data   <= '0;
            fault_q    <= F_OK;
        end else if (accept) begin
            fault_q  <= req_fault;
            rsp_data <= '0;
            // Faulting requests leave the memory port untouched
            if (clean) begin
                we_q       <= req_we;
                mem_addr   <= req_addr;
                mem_funct3 <= req_funct3;
                mem_wdata  <= req_wdata;
            end
        end else if (state == CAPTURE) begin
            rsp_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a registered data memory model and a reference memory.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_fault;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [2:0]  mem_funct3;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'h0;

    lsu_ctrl #(.BUS_BITS(64), .ADDR_BITS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_funct3(mem_funct3),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]     data;
        logic [63:0]     alt;
        bit              has_alt;
        logic [1:0]      fault;
        int unsigned     lat;
        longint unsigned acc;
    } exp_t;

    exp_t            q[$];
    int unsigned     checks = 0;
    int unsigned     errors = 0;
    longint unsigned cyc = 0;
    int unsigned     we_cnt = 0;
    int unsigned     exp_we_cnt = 0;
    int unsigned     rdy_mode = 0;
    logic            rdy_force = 1'b1;
    int unsigned     last_wait;
    logic            last_rv;
    logic [7:0]      env_mem [0:65535] = '{default: 8'h00};
    logic [7:0]      ref_mem [0:65535] = '{default: 8'h00};

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Data memory model: byte store by size, registered extended load
    function automatic logic [63:0] env_load(logic [15:0] a, logic [2:0] f3);
        logic [63:0] raw;
        for (int i = 0; i < 8; i++) raw[8*i +: 8] = env_mem[16'(a + 16'(i))];
        case (f3)
            3'd0:    return {{56{raw[7]}}, raw[7:0]};
            3'd1:    return {{48{raw[15]}}, raw[15:0]};
            3'd2:    return {{32{raw[31]}}, raw[31:0]};
            3'd3:    return raw;
            3'd4:    return {56'h0, raw[7:0]};
            3'd5:    return {48'h0, raw[15:0]};
            3'd6:    return {32'h0, raw[31:0]};
            default: return 64'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < (1 << mem_funct3[1:0]); i++)
                env_mem[16'(mem_addr[15:0] + 16'(i))] <= mem_wdata[8*i +: 8];
        end
        mem_rdata <= env_load(mem_addr[15:0], mem_funct3);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: classify from the rules, then apply to a byte array
    function automatic exp_t ref_model(bit we, logic [2:0] f3, logic [63:0] a, logic [63:0] d);
        exp_t        e;
        int unsigned size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        v = 64'h0;
        e.data = 64'h0; e.alt = 64'h0; e.has_alt = 0; e.acc = 0;
        if (we ? (f3 > 3) : (f3 == 7))  e.fault = 2'd2;
        else if (a >= 64'h10000)        e.fault = 2'd3;
        else if ((a % size) != 0)       e.fault = 2'd1;
        else                            e.fault = 2'd0;
        if (e.fault != 0) begin
            e.lat = 1;
        end else if (we) begin
            e.lat = 2;
            for (int i = 0; i < int'(size); i++) ref_mem[int'(a[15:0]) + i] = d[8*i +: 8];
            exp_we_cnt++;
        end else begin
            e.lat = 3;
            for (int i = int'(size) - 1; i >= 0; i--) v = (v << 8) | 64'(ref_mem[int'(a[15:0]) + i]);
            if (f3 < 4 && size < 8 && v[8*size-1]) v = v - (64'd1 << (8*size));
            e.data = v;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per response handshake
    bit              seen = 0;
    longint unsigned first_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 0;
        end else begin
            if (mem_we) we_cnt++;
            if (rsp_valid && !seen) begin
                seen = 1;
                first_cyc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    if (e.has_alt && rsp_data === e.alt) chk("rsp_data", rsp_data, e.alt);
                    else chk("rsp_data", rsp_data, e.data);
                    chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
                    chk("rsp_latency", 64'(first_cyc - e.acc), 64'(e.lat - 1));
                end
                seen = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = rdy_force;
            endcase
        end
    end

    // Entered and left at posedge+1; consecutive calls keep req_valid asserted
    task automatic issue(input bit we, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
        exp_t e;
        bit   ok;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        last_wait = 0;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
            last_wait++;
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        last_rv = rsp_valid;
        e = ref_model(we, f3, a, d);
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !rsp_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) chk({name, "_drain_timeout"}, 64'(q.size()), 64'd0);
        chk({name, "_mem_we_pulses"}, 64'(we_cnt), 64'(exp_we_cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cap_d;
        logic [1:0]  cap_f;
        logic [63:0] old_v;
        logic [7:0]  saved [0:7];
        bit          got;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 64'h0; req_wdata = 64'h0; rsp_ready = 1'b1;
        #12;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'h0);
        chk("reset_rsp_fault", 64'(rsp_fault), 64'd0);
        chk("reset_mem_we", 64'(mem_we), 64'd0);
        chk("reset_mem_addr", mem_addr, 64'h0);
        chk("reset_mem_funct3", 64'(mem_funct3), 64'd0);
        chk("reset_mem_wdata", mem_wdata, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1-2: store then load back, with extension variants
        issue(1, 3'd3, 64'h10, 64'h1122334455667788);
        issue(0, 3'd3, 64'h10, 64'h0);
        issue(1, 3'd0, 64'h20, 64'h80);
        issue(0, 3'd0, 64'h20, 64'h0);
        issue(0, 3'd4, 64'h20, 64'h0);
        drain("basic");

        // 3: faults never reach memory
        issue(0, 3'd2, 64'h22, 64'h0);
        issue(1, 3'd7, 64'h10, 64'hDEAD);
        issue(0, 3'd3, 64'h10000, 64'h0);
        issue(1, 3'd4, 64'h10, 64'hBEEF);
        drain("faults");

        // 4: backpressure, then response and request handshake on one edge
        rdy_force = 1'b0;
        rdy_mode = 2;
        @(posedge clk);
        #1;
        issue(0, 3'd3, 64'h10, 64'h0);
        got = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        chk("hold_rsp_seen", 64'(got), 64'd1);
        cap_d = rsp_data;
        cap_f = rsp_fault;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_data", rsp_data, cap_d);
            chk("hold_rsp_fault", 64'(rsp_fault), 64'(cap_f));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 3'd0, 64'h30, 64'h5A);
        chk("same_edge_wait", 64'(last_wait), 64'd0);
        chk("same_edge_rsp_valid", 64'(last_rv), 64'd1);
        rdy_mode = 0;
        drain("backpressure");

        // 5: reset during a store's ISSUE cycle
        for (int i = 0; i < 8; i++) saved[i] = ref_mem[16'h100 + i];
        old_v = 64'h0;
        for (int i = 7; i >= 0; i--) old_v = (old_v << 8) | 64'(saved[i]);
        issue(1, 3'd3, 64'h100, 64'hCAFEF00D12345678);
        chk("abort_mem_we_before", 64'(mem_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", 64'(mem_we), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_mem_addr", mem_addr, 64'h0);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        void'(q.pop_back());
        exp_we_cnt--;
        for (int i = 0; i < 8; i++) ref_mem[16'h100 + i] = saved[i];
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 3'd3, 64'h100, 64'h0);
        q[$].has_alt = 1;
        q[$].alt = 64'hCAFEF00D12345678;
        q[$].data = old_v;
        drain("reset");

        // 6: random legal traffic with random response backpressure
        rdy_mode = 1;
        for (int n = 0; n < 100; n++) begin
            bit          we;
            logic [2:0]  f3;
            int unsigned size;
            logic [63:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            size = 1 << f3[1:0];
            a = 64'h1000 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 8 / size - 1) * size);
            issue(we, f3, a, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain("random");
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
